// File: rtl/anabellek_denetleyici_pkg.sv
// Shared widths and block geometry for the main-memory block-read controller.
// Block = four words; the low four address bits select the byte within it.
package anabellek_denetleyici_pkg;

  localparam int BUYRUK_ADRES_BIT        = 32;
  localparam int BUYRUK_VERI_BIT         = 32;
  localparam int ANABELLEK_BLOK_KELIME   = 4;
  localparam int ANABELLEK_BLOK_HIZALAMA = 4;
  localparam int BUYRUK_BLOK_BIT         = BUYRUK_VERI_BIT * ANABELLEK_BLOK_KELIME;

  typedef logic [1:0] sayac_t;

  // Byte offset of word 'sayac' inside the aligned block.
  function automatic logic [ANABELLEK_BLOK_HIZALAMA-1:0] kelime_ofseti(input sayac_t sayac);
    return {sayac, 2'b00};
  endfunction

endpackage

// File: rtl/anabellek_denetleyici_if.sv
// Cache-side block-read handshake plus the word-wide memory port.
interface anabellek_denetleyici_if
  import anabellek_denetleyici_pkg::*;
#(
  parameter int ADRES_BIT = BUYRUK_ADRES_BIT,
  parameter int VERI_BIT  = BUYRUK_VERI_BIT,
  parameter int BLOK_BIT  = BUYRUK_BLOK_BIT
) ();

  logic [ADRES_BIT-1:0] okuma_istek_adres_i;
  logic                 okuma_istek_gecerli_i;
  logic [BLOK_BIT-1:0]  okuma_veri_blok_o;
  logic                 okuma_istek_hazir_o;
  logic                 bellek_istek_gecerli_o;
  logic [ADRES_BIT-1:0] bellek_istek_adres_o;
  logic                 bellek_istek_hazir_i;
  logic [VERI_BIT-1:0]  bellek_veri_i;
  logic                 bellek_veri_gecerli_i;

  modport slave (
    input  okuma_istek_adres_i, okuma_istek_gecerli_i,
    output okuma_veri_blok_o, okuma_istek_hazir_o,
    output bellek_istek_gecerli_o, bellek_istek_adres_o,
    input  bellek_istek_hazir_i, bellek_veri_i, bellek_veri_gecerli_i
  );

  modport master (
    output okuma_istek_adres_i, okuma_istek_gecerli_i,
    input  okuma_veri_blok_o, okuma_istek_hazir_o,
    input  bellek_istek_gecerli_o, bellek_istek_adres_o,
    output bellek_istek_hazir_i, bellek_veri_i, bellek_veri_gecerli_i
  );

endinterface

// File: rtl/anabellek_denetleyici.sv
// Fetches the aligned 4-word block around a miss address one word at a time; 11 cycles min per block.
// Memory stalls on accept or data stretch the fetch cycle for cycle; hazir pulses once per block.
module anabellek_denetleyici
  import anabellek_denetleyici_pkg::*;
#(
  parameter int ADRES_BIT = BUYRUK_ADRES_BIT,
  parameter int VERI_BIT  = BUYRUK_VERI_BIT,
  parameter int BLOK_BIT  = BUYRUK_BLOK_BIT
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  anabellek_denetleyici_if.slave bus
);

  localparam logic [2:0] BOSTA        = 3'd0;
  localparam logic [2:0] KELIME_ISTE  = 3'd1;
  localparam logic [2:0] KELIME_BEKLE = 3'd2;
  localparam logic [2:0] HAZIR        = 3'd3;
  localparam logic [2:0] SOGUMA       = 3'd4;

  localparam logic [ADRES_BIT-1:0] HIZA_MASKE =
    ADRES_BIT'((1 << ANABELLEK_BLOK_HIZALAMA) - 1);

  logic [2:0]           durum;
  sayac_t               sayac;
  logic [ADRES_BIT-1:0] taban;
  logic [BLOK_BIT-1:0]  blok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum <= BOSTA;
      sayac <= '0;
      taban <= '0;
      blok  <= '0;
    end else begin
      case (durum)
        BOSTA: begin
          if (bus.okuma_istek_gecerli_i) begin
            taban <= bus.okuma_istek_adres_i & ~HIZA_MASKE;
            sayac <= '0;
            durum <= KELIME_ISTE;
          end
        end
        KELIME_ISTE: begin
          if (bus.bellek_istek_hazir_i) durum <= KELIME_BEKLE;
        end
        KELIME_BEKLE: begin
          if (bus.bellek_veri_gecerli_i) begin
            blok[sayac*VERI_BIT +: VERI_BIT] <= bus.bellek_veri_i;
            if (sayac == 2'd3) begin
              durum <= HAZIR;
            end else begin
              sayac <= sayac + 2'd1;
              durum <= KELIME_ISTE;
            end
          end
        end
        HAZIR:   durum <= SOGUMA;
        // Requester may still be holding valid from the finished block.
        SOGUMA:  durum <= BOSTA;
        default: durum <= BOSTA;
      endcase
    end
  end

  assign bus.okuma_istek_hazir_o    = (durum == HAZIR);
  assign bus.bellek_istek_gecerli_o = (durum == KELIME_ISTE);
  assign bus.bellek_istek_adres_o   = (durum == KELIME_ISTE)
                                    ? (taban | ADRES_BIT'(kelime_ofseti(sayac)))
                                    : '0;
  assign bus.okuma_veri_blok_o      = blok;

endmodule
